// File: rtl/id_decode_regfile_pkg.sv
// Shared decode constants and the control-signal bundle carried down the pipeline.
// Opcode/funct encodings, ALUOp and ALU-control codes, and the signal_t struct.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_SLT     = 6'b101010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_LUI   = 3'b100;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc;
        logic [2:0] ALUOp;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       jump;
        logic       jr;
        logic       func;
        logic       finish;
    } signal_t;

endpackage

// File: rtl/id_decode_regfile_alu_ctrl.sv
// ALU-control decode: ALUOp plus funct to the 4-bit EX operation code.
// EX zero-extends the immediate only for the OR code, so ori must map there.
module alu_ctrl
    import id_pkg::*;
(
    input  logic [2:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctrl
);

    logic [3:0] w_funct_ctrl;

    always_comb begin
        w_funct_ctrl = ALU_ADD;
        case (i_funct)
            FN_ADD, FN_ADDU: w_funct_ctrl = ALU_ADD;
            FN_SUB, FN_SUBU: w_funct_ctrl = ALU_SUB;
            FN_AND:          w_funct_ctrl = ALU_AND;
            FN_OR:           w_funct_ctrl = ALU_OR;
            FN_SLT:          w_funct_ctrl = ALU_SLT;
            default:         w_funct_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_ctrl = ALU_ADD;
            ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: o_alu_ctrl = w_funct_ctrl;
            ALUOP_OR:    o_alu_ctrl = ALU_OR;
            ALUOP_LUI:   o_alu_ctrl = ALU_LUI;
            default:     o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_decode_regfile_main_ctrl.sv
// Main control decode: opcode (and funct for jr/syscall) to the signal_t bundle.
// Unknown opcodes decode to an all-zero bubble.
module main_ctrl
    import id_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output signal_t    o_sig
);

    always_comb begin
        o_sig = '0;
        case (i_opcode)
            OP_RTYPE: begin
                o_sig.ALUOp = ALUOP_FUNCT;
                if (i_funct == FN_JR) begin
                    o_sig.jr = 1'b1;
                end else if (i_funct == FN_SYSCALL) begin
                    o_sig.finish = 1'b1;
                end else begin
                    o_sig.RegDst   = 1'b1;
                    o_sig.RegWrite = 1'b1;
                end
            end
            OP_LW: begin
                o_sig.ALUSrc   = 1'b1;
                o_sig.MemtoReg = 1'b1;
                o_sig.RegWrite = 1'b1;
                o_sig.MemRead  = 1'b1;
                o_sig.ALUOp    = ALUOP_ADD;
            end
            OP_SW: begin
                o_sig.ALUSrc   = 1'b1;
                o_sig.MemWrite = 1'b1;
                o_sig.ALUOp    = ALUOP_ADD;
            end
            OP_BEQ: begin
                o_sig.Branch = 1'b1;
                o_sig.ALUOp  = ALUOP_SUB;
            end
            OP_ADDI, OP_ADDIU: begin
                o_sig.ALUSrc   = 1'b1;
                o_sig.RegWrite = 1'b1;
                o_sig.ALUOp    = ALUOP_ADD;
            end
            OP_ORI: begin
                o_sig.ALUSrc   = 1'b1;
                o_sig.RegWrite = 1'b1;
                o_sig.ALUOp    = ALUOP_OR;
            end
            OP_LUI: begin
                o_sig.ALUSrc   = 1'b1;
                o_sig.RegWrite = 1'b1;
                o_sig.ALUOp    = ALUOP_LUI;
            end
            OP_J: begin
                o_sig.jump = 1'b1;
            end
            // Destination $31 and the pc+8 link value are selected downstream.
            OP_JAL: begin
                o_sig.jump     = 1'b1;
                o_sig.func     = 1'b1;
                o_sig.RegWrite = 1'b1;
            end
            default: o_sig = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_regfile_reg_file.sv
// 32x32 register file with two combinational write-through read ports.
// $0 is hard-wired to zero; reset clears storage asynchronously and blocks writes.
module reg_file (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [31:0] i_wb_pc,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_regwrite,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_reg1,
    output logic [31:0] o_reg2
);

    logic [31:0] r_regs [0:31];
    logic        w_wr_en;

    assign w_wr_en = i_wb_regwrite && (i_wb_rd != 5'd0) && !i_reset;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    // Forward the WB value so an instruction reading its producer's target in ID sees it now.
    always_comb begin
        if (i_rs == 5'd0)
            o_reg1 = '0;
        else if (w_wr_en && i_wb_rd == i_rs)
            o_reg1 = i_wb_data;
        else
            o_reg1 = r_regs[i_rs];
    end

    always_comb begin
        if (i_rt == 5'd0)
            o_reg2 = '0;
        else if (w_wr_en && i_wb_rd == i_rt)
            o_reg2 = i_wb_data;
        else
            o_reg2 = r_regs[i_rt];
    end

`ifndef SYNTHESIS
    always @(posedge i_clock) begin
        if (w_wr_en)
            $display("@%h: $%d <= %h", i_wb_pc, i_wb_rd, i_wb_data);
    end
`endif

endmodule

// File: rtl/id_decode_regfile.sv
// ID stage: main decode, ALU-control decode and the register file, wired together.
// Everything except register contents is combinational on inst.
module id_decode_regfile
    import id_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic [31:0] wb_data,
    output signal_t     sig,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] reg1,
    output logic [31:0] reg2
);

    signal_t w_sig;
    logic    w_unused_bits;

    // rd, shamt and the immediate are consumed by later stages, not here.
    assign w_unused_bits = ^inst[15:6];

    main_ctrl u_main_ctrl (
        .i_opcode (inst[31:26]),
        .i_funct  (inst[5:0]),
        .o_sig    (w_sig)
    );

    alu_ctrl u_alu_ctrl (
        .i_alu_op   (w_sig.ALUOp),
        .i_funct    (inst[5:0]),
        .o_alu_ctrl (alu_ctrl)
    );

    reg_file u_reg_file (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_rs          (inst[25:21]),
        .i_rt          (inst[20:16]),
        .i_wb_pc       (wb_pc),
        .i_wb_rd       (wb_rd),
        .i_wb_regwrite (wb_regwrite),
        .i_wb_data     (wb_data),
        .o_reg1        (reg1),
        .o_reg2        (reg2)
    );

    assign sig = w_sig;

endmodule

// File: tb/tb_id_decode_regfile.sv
// Directed bench for id_decode_regfile: register-file reset/write-through and decode tables.
// Expected values are hand-computed from the instruction encodings.
module tb_id_decode_regfile;
    import id_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    signal_t     sig;
    logic [3:0]  alu_ctrl;
    logic [31:0] reg1;
    logic [31:0] reg2;

    int checks;
    int failures;

    id_decode_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .inst        (inst),
        .wb_pc       (wb_pc),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .wb_data     (wb_data),
        .sig         (sig),
        .alu_ctrl    (alu_ctrl),
        .reg1        (reg1),
        .reg2        (reg2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Flag bits in struct order, ALUOp left out:
    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,jump,jr,func,finish}
    function automatic logic [10:0] flags(input signal_t s);
        return {s.RegDst, s.ALUSrc, s.MemtoReg, s.RegWrite, s.MemRead, s.MemWrite,
                s.Branch, s.jump, s.jr, s.func, s.finish};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic decode(input string tag, input logic [31:0] word,
                          input logic [10:0] exp_flags, input logic [3:0] exp_alu);
        inst = word;
        #1;
        chk({tag, "_flags"}, {21'd0, flags(sig)}, {21'd0, exp_flags});
        chk({tag, "_alu"}, {28'd0, alu_ctrl}, {28'd0, exp_alu});
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        inst        = 32'h0;
        wb_pc       = 32'h0040_0000;
        wb_rd       = 5'd0;
        wb_regwrite = 1'b0;
        wb_data     = 32'h0;

        #12;
        chk("reset_reg1", reg1, 32'h0);
        chk("reset_reg2", reg2, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Write $5 = 0x1234, then assert reset with no clock edge.
        wb_rd = 5'd5; wb_data = 32'h0000_1234; wb_regwrite = 1'b1;
        step_edge();
        wb_regwrite = 1'b0;
        inst = 32'h00A0_0000;               // rs=5
        #1;
        chk("w5_read", reg1, 32'h0000_1234);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_reset_r5", reg1, 32'h0);
        #1;
        reset = 1'b0;
        @(negedge clock);

        // Write-through to $8, then readback after the edge on both ports.
        inst = 32'h0100_0000;               // rs=8
        wb_pc = 32'h0040_0010; wb_rd = 5'd8; wb_data = 32'hDEAD_BEEF; wb_regwrite = 1'b1;
        #1;
        chk("bypass_rs8", reg1, 32'hDEAD_BEEF);
        step_edge();
        wb_regwrite = 1'b0;
        #1;
        chk("stored_rs8", reg1, 32'hDEAD_BEEF);
        inst = 32'h0008_0000;               // rt=8
        #1;
        chk("stored_rt8", reg2, 32'hDEAD_BEEF);

        // Bypass must match the address: rs=9 does not see a $8 write.
        inst = 32'h0120_0000;               // rs=9
        wb_rd = 5'd8; wb_data = 32'h1111_2222; wb_regwrite = 1'b1;
        #1;
        chk("no_bypass_rs9", reg1, 32'h0);
        wb_regwrite = 1'b0;
        #1;

        // Write to $0 is discarded.
        @(negedge clock);
        inst = 32'h0000_0000;
        wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; wb_regwrite = 1'b1;
        #1;
        chk("r0_bypass_rs", reg1, 32'h0);
        chk("r0_bypass_rt", reg2, 32'h0);
        step_edge();
        wb_regwrite = 1'b0;
        #1;
        chk("r0_after_rs", reg1, 32'h0);
        chk("r0_after_rt", reg2, 32'h0);

        // Decode table. Flag order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite
        //                           Branch jump jr func finish
        decode("ori",     32'h3508_FFFF, 11'b010_1000_0000, ALU_OR);
        chk("ori_rs8", reg1, 32'hDEAD_BEEF);
        decode("lw",      32'h8D09_0004, 11'b011_1100_0000, ALU_ADD);
        decode("sw",      32'hAC01_0000, 11'b010_0010_0000, ALU_ADD);
        decode("addiu",   32'h2401_0005, 11'b010_1000_0000, ALU_ADD);
        decode("addi",    32'h2001_FFFF, 11'b010_1000_0000, ALU_ADD);
        decode("lui",     32'h3C01_1234, 11'b010_1000_0000, ALU_LUI);
        decode("sub",     32'h0022_1822, 11'b100_1000_0000, ALU_SUB);
        decode("subu",    32'h0022_1823, 11'b100_1000_0000, ALU_SUB);
        decode("addu",    32'h0022_1821, 11'b100_1000_0000, ALU_ADD);
        decode("and",     32'h0022_1824, 11'b100_1000_0000, ALU_AND);
        decode("or",      32'h0022_1825, 11'b100_1000_0000, ALU_OR);
        decode("slt",     32'h0022_182A, 11'b100_1000_0000, ALU_SLT);
        decode("sll_nop", 32'h0000_0000, 11'b100_1000_0000, ALU_ADD);
        decode("jr",      32'h03E0_0008, 11'b000_0000_0100, ALU_ADD);
        decode("syscall", 32'h0000_000C, 11'b000_0000_0001, ALU_ADD);
        decode("j",       32'h0800_0010, 11'b000_0000_1000, ALU_ADD);
        decode("jal",     32'h0C00_0010, 11'b000_1000_1010, ALU_ADD);
        decode("beq",     32'h1022_0003, 11'b000_0001_0000, ALU_SUB);
        decode("op3f",    32'hFC00_0000, 11'b000_0000_0000, ALU_ADD);

        inst = 32'h3C01_1234;
        #1;
        chk("lui_aluop", {29'd0, sig.ALUOp}, {29'd0, ALUOP_LUI});
        inst = 32'h1022_0003;
        #1;
        chk("beq_aluop", {29'd0, sig.ALUOp}, {29'd0, ALUOP_SUB});
        inst = 32'hFC00_0000;
        #1;
        chk("bubble_aluop", {29'd0, sig.ALUOp}, {29'd0, ALUOP_ADD});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
